// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game-flow controller.
package dino_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/dino_bcd_inc.sv
// Combinational DIGITS-wide BCD increment that holds at all-9s.
// carry_hundreds flags an increment whose carry reaches digit 2.
module dino_bcd_inc
   import dino_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] value,
   output logic [4*DIGITS-1:0] next_value,
   output logic                carry_hundreds
);

   logic all_nine;
   logic carry;

   // Ripple a +1 through the digits; hold the value if every digit is already 9
   always_comb begin
      next_value     = value;
      carry          = 1'b1;
      all_nine       = 1'b1;
      carry_hundreds = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_digit_t'(value[4*i +: 4]) != BCD_NINE) all_nine = 1'b0;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (i == 2) carry_hundreds = 1'b1;
            if (bcd_digit_t'(value[4*i +: 4]) == BCD_NINE) begin
               next_value[4*i +: 4] = 4'd0;
            end else begin
               next_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
               carry                = 1'b0;
            end
         end
      end
      if (all_nine) begin
         next_value     = value;
         carry_hundreds = 1'b0;
      end
   end

endmodule

// File: rtl/dino_game_ctrl.sv
// Game-flow controller: IDLE/RUN/OVER state machine, BCD score and high score.
// Optional macro DINO_SPEEDUP_EN builds a 2-bit difficulty counter that steps
// each time the score rolls into a new hundred; otherwise speed_level is 0.
module dino_game_ctrl
   import dino_pkg::*;
#(
   parameter int DIGITS           = 4,
   parameter int SCORE_STEP_TICKS = 4,
   parameter int HOLD_TICKS       = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                jump_button,
   input  logic                collision,
   output logic                run_en,
   output logic                restart,
   output logic                game_over,
   output logic [4*DIGITS-1:0] score,
   output logic [4*DIGITS-1:0] hi_score,
   output logic [1:0]          speed_level
);

   localparam logic [7:0] PACE_LAST = 8'(SCORE_STEP_TICKS - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS);

   state_t               state_q;
   state_t               state_d;
   logic                 jump_prev;
   logic                 jump_rise;
   logic [7:0]           pace_q;
   logic [7:0]           hold_q;
   logic                 start_game;
   logic                 enter_over;
   logic                 score_step;
   logic [4*DIGITS-1:0]  score_next;
   logic                 carry_hundreds;

   assign jump_rise = jump_button & ~jump_prev;

   dino_bcd_inc #(.DIGITS(DIGITS)) u_bcd_inc (
      .value          (score),
      .next_value     (score_next),
      .carry_hundreds (carry_hundreds)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and per-cycle event decode; collision outranks scoring and jumps
   always_comb begin
      state_d    = state_q;
      start_game = 1'b0;
      enter_over = 1'b0;
      score_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (jump_rise) begin
               state_d    = RUN;
               start_game = 1'b1;
            end
         end
         RUN: begin
            if (collision) begin
               state_d    = OVER;
               enter_over = 1'b1;
            end else if (tick && pace_q == PACE_LAST) begin
               score_step = 1'b1;
            end
         end
         OVER: begin
            if (hold_q == HOLD_LAST && jump_rise) begin
               state_d    = RUN;
               start_game = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, counters, score and high score
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jump_prev <= 1'b0;
         run_en    <= 1'b0;
         restart   <= 1'b0;
         game_over <= 1'b0;
         pace_q    <= 8'd0;
         hold_q    <= 8'd0;
         score     <= '0;
         hi_score  <= '0;
      end else begin
         jump_prev <= jump_button;
         restart   <= start_game;
         run_en    <= (state_d == RUN);
         game_over <= (state_d == OVER);
         if (start_game) begin
            score  <= '0;
            pace_q <= 8'd0;
            hold_q <= 8'd0;
         end else begin
            if (state_q == RUN && !collision && tick) begin
               pace_q <= (pace_q == PACE_LAST) ? 8'd0 : pace_q + 8'd1;
            end
            if (score_step) score <= score_next;
            if (enter_over) begin
               hold_q <= 8'd0;
               if (score > hi_score) hi_score <= score;
            end
            if (state_q == OVER && tick && hold_q < HOLD_LAST) begin
               hold_q <= hold_q + 8'd1;
            end
         end
      end
   end

`ifdef DINO_SPEEDUP_EN
   // Difficulty rises once per hundred points, capped at 3, cleared on restart
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         speed_level <= 2'd0;
      end else if (start_game) begin
         speed_level <= 2'd0;
      end else if (score_step && carry_hundreds && speed_level != 2'd3) begin
         speed_level <= speed_level + 2'd1;
      end
   end
`else
   logic unused_carry_hundreds;
   assign unused_carry_hundreds = carry_hundreds;
   assign speed_level           = 2'd0;
`endif

endmodule
